// File: rtl/bitonic_sort_ctrl.sv
// bitonic_sort_ctrl
//   Word-serial front end for a parallel bitonic sorter. Gathers up to
//   NUM_INPUT words from the input stream into a lane buffer and pads the
//   unused lanes with all-ones. It then presents the vector to the sorter,
//   waits for done and captures the result. Finally it streams the real
//   words back out in ascending order.
//
// Ports
//   clk, reset           : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    : input word handshake; in_data word, in_last ends batch
//   sort_data_in         : parallel vector to sorter (lane i at [DW*(i+1)-1 -: DW])
//   sort_valid/sort_done : sorter request / completion
//   sort_data_out        : sorted vector from sorter, lane 0 smallest
//   out_valid/out_ready  : output word handshake; out_data word, out_last ends batch
//   busy                 : high while sorting or draining
//   sort_timeout         : sticky flag, sorter missed the MAX_WAIT deadline
module bitonic_sort_ctrl #(
    parameter int unsigned NUM_INPUT  = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_WAIT   = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic                            in_last,
    output logic [NUM_INPUT*DATA_WIDTH-1:0] sort_data_in,
    output logic                            sort_valid,
    input  logic                            sort_done,
    input  logic [NUM_INPUT*DATA_WIDTH-1:0] sort_data_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_last,
    output logic                            busy,
    output logic                            sort_timeout
);

    localparam int unsigned CW = $clog2(NUM_INPUT + 1);
    localparam int unsigned IW = $clog2(NUM_INPUT);
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                               state_q, state_d;
    logic [CW-1:0]                        count_q, count_d;
    logic [IW-1:0]                        rd_idx_q, rd_idx_d;
    logic [WW-1:0]                        wait_q, wait_d;
    logic [NUM_INPUT-1:0][DATA_WIDTH-1:0] lanes_q, lanes_d;
    logic [NUM_INPUT-1:0][DATA_WIDTH-1:0] result_q, result_d;
    logic [NUM_INPUT-1:0][DATA_WIDTH-1:0] sorted_lanes;
    logic                                 in_ready_q, in_ready_d;
    logic                                 sort_valid_q, sort_valid_d;
    logic                                 out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]                out_data_q, out_data_d;
    logic                                 out_last_q, out_last_d;
    logic                                 busy_q, busy_d;
    logic                                 timeout_q, timeout_d;

    assign sorted_lanes = sort_data_out;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rd_idx_d     = rd_idx_q;
        wait_d       = wait_q;
        lanes_d      = lanes_q;
        result_d     = result_q;
        in_ready_d   = in_ready_q;
        sort_valid_d = sort_valid_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        busy_d       = busy_q;
        timeout_d    = timeout_q;

        case (state_q)
            FILL: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    for (int unsigned i = 0; i < NUM_INPUT; i++) begin
                        if (CW'(i) == count_q) begin
                            lanes_d[i] = in_data;
                        end
                    end
                    count_d = count_q + 1'b1;
                    if (in_last || count_q == CW'(NUM_INPUT - 1)) begin
                        // Pads are all-ones so they sort above every real word.
                        for (int unsigned i = 0; i < NUM_INPUT; i++) begin
                            if (CW'(i) > count_q) begin
                                lanes_d[i] = '1;
                            end
                        end
                        in_ready_d   = 1'b0;
                        sort_valid_d = 1'b1;
                        busy_d       = 1'b1;
                        wait_d       = '0;
                        state_d      = SORT;
                    end
                end
            end

            SORT: begin
                // done is checked first so it wins over a same-cycle timeout.
                if (sort_done) begin
                    result_d     = sorted_lanes;
                    sort_valid_d = 1'b0;
                    rd_idx_d     = '0;
                    out_valid_d  = 1'b1;
                    out_data_d   = sorted_lanes[0];
                    out_last_d   = (count_q == CW'(1));
                    state_d      = DRAIN;
                end else if (wait_q == WW'(MAX_WAIT - 1)) begin
                    timeout_d    = 1'b1;
                    sort_valid_d = 1'b0;
                    count_d      = '0;
                    busy_d       = 1'b0;
                    in_ready_d   = 1'b1;
                    state_d      = FILL;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            DRAIN: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        count_d     = '0;
                        busy_d      = 1'b0;
                        in_ready_d  = 1'b1;
                        state_d     = FILL;
                    end else begin
                        rd_idx_d   = rd_idx_q + 1'b1;
                        out_data_d = result_q[rd_idx_d];
                        out_last_d = (CW'(rd_idx_d) == count_q - 1'b1);
                    end
                end
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FILL;
            count_q      <= '0;
            rd_idx_q     <= '0;
            wait_q       <= '0;
            lanes_q      <= '0;
            result_q     <= '0;
            in_ready_q   <= 1'b0;
            sort_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_idx_q     <= rd_idx_d;
            wait_q       <= wait_d;
            lanes_q      <= lanes_d;
            result_q     <= result_d;
            in_ready_q   <= in_ready_d;
            sort_valid_q <= sort_valid_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign sort_data_in = lanes_q;
    assign sort_valid   = sort_valid_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign busy         = busy_q;
    assign sort_timeout = timeout_q;

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Testbench for bitonic_sort_ctrl: table-driven batches, randomized batches
// against a sorted-queue reference, plus timeout and mid-drain reset sequences.
module tb_bitonic_sort_ctrl;

    localparam int unsigned N  = 8;
    localparam int unsigned DW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic            in_last = 1'b0;
    logic [N*DW-1:0] sort_data_in;
    logic            sort_valid;
    logic            sort_done = 1'b0;
    logic [N*DW-1:0] sort_data_out = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            busy;
    logic            sort_timeout;

    bitonic_sort_ctrl #(
        .NUM_INPUT (N),
        .DATA_WIDTH(DW),
        .MAX_WAIT  (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .sort_data_in (sort_data_in),
        .sort_valid   (sort_valid),
        .sort_done    (sort_done),
        .sort_data_out(sort_data_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .sort_timeout (sort_timeout)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tmo_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Reference sorter: plain ascending sort of the eight lanes.
    function automatic logic [63:0] sort8(input logic [63:0] v);
        logic [7:0]  a [8];
        logic [7:0]  t;
        logic [63:0] r;
        for (int i = 0; i < 8; i++) a[i] = v[8*i +: 8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 7 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        for (int i = 0; i < 8; i++) r[8*i +: 8] = a[i];
        return r;
    endfunction

    // Sorter model: done 3 cycles after valid rises, held until valid drops.
    logic        hang = 1'b0;
    int unsigned vcnt = 0;
    always @(negedge clk) begin
        if (sort_valid && !hang) begin
            if (vcnt < 3) vcnt++;
        end else begin
            vcnt = 0;
        end
        sort_done     = (vcnt >= 3);
        sort_data_out = sort8(sort_data_in);
    end

    // Output monitor: drives out_ready, records handshakes, checks stall hold.
    int unsigned bp_mode = 0;
    int unsigned pat_i = 0;
    logic [5:0]  pat = 6'b101001;   // 1,0,0,1,0,1 from bit 0 upward
    logic [7:0]  got_data [$];
    logic        got_last [$];
    logic        last_seen = 1'b0;
    int unsigned ovalid_seen = 0;
    logic        hold_pend = 1'b0;
    logic [9:0]  hold_val = '0;

    always @(negedge clk) begin
        case (bp_mode)
            1: begin
                out_ready = pat[pat_i];
                pat_i = (pat_i == 5) ? 0 : pat_i + 1;
            end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
        if (!reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) chk("stall_hold", {54'd0, out_valid, out_last, out_data}, {54'd0, hold_val});
            if (out_valid) begin
                ovalid_seen++;
                chk("busy_in_drain", busy, 1);
            end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                if (out_last) last_seen = 1'b1;
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = {out_valid, out_last, out_data};
        end
    end

    logic [7:0] in_q [$];
    logic [7:0] exp_q [$];

    task automatic send_batch();
        int unsigned n = in_q.size();
        for (int i = 0; i < int'(n); i++) begin
            int unsigned t = 0;
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                tmo_fail("in_ready_wait");
                in_valid = 1'b0;
                return;
            end
            in_valid = 1'b1;
            in_data  = in_q[i];
            in_last  = (i == int'(n) - 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    function automatic logic [63:0] lanes_of(input int unsigned dummy);
        logic [63:0] r = '1;
        for (int i = 0; i < in_q.size(); i++) r[8*i +: 8] = in_q[i];
        return r + 64'(dummy);
    endfunction

    task automatic run_and_check(input string tag, input logic [63:0] exp_lanes, input int unsigned bp);
        int unsigned t = 0;
        got_data.delete();
        got_last.delete();
        last_seen   = 1'b0;
        ovalid_seen = 0;
        bp_mode     = bp;
        send_batch();
        chk({tag, "_lanes"}, sort_data_in, exp_lanes);
        chk({tag, "_sort_valid"}, sort_valid, 1);
        chk({tag, "_busy_sort"}, busy, 1);
        while (!last_seen && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!last_seen) begin
            tmo_fail({tag, "_drain"});
            return;
        end
        @(negedge clk);
        chk({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_in_ready_end"}, in_ready, 1);
        chk({tag, "_out_valid_end"}, out_valid, 1'b0);
        chk({tag, "_count"}, 64'(got_data.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            chk({tag, "_data"}, 64'(got_data[i]), 64'(exp_q[i]));
            chk({tag, "_last"}, 64'(got_last[i]), 64'(i == exp_q.size() - 1));
        end
        bp_mode = 0;
    endtask

    typedef struct {
        logic [63:0] words;
        int unsigned n;
        int unsigned bp;
        logic [63:0] exp_lanes;
        logic [63:0] exp_sorted;
    } vec_t;

    vec_t tbl [3];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{64'h04_06_02_07_01_08_03_05, 8, 0,
                   64'h04_06_02_07_01_08_03_05, 64'h08_07_06_05_04_03_02_01};
        tbl[1] = '{64'h00_00_00_00_00_05_02_09, 3, 0,
                   64'hFF_FF_FF_FF_FF_05_02_09, 64'h00_00_00_00_00_09_05_02};
        tbl[2] = '{64'h04_06_02_07_01_08_03_05, 8, 1,
                   64'h04_06_02_07_01_08_03_05, 64'h08_07_06_05_04_03_02_01};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sort_valid", sort_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", sort_timeout, 0);
        chk("rst_lanes", sort_data_in, 0);
        reset = 1'b1;
        #1 chk("rel_in_ready_pre", in_ready, 0);
        @(posedge clk);
        #1 chk("rel_in_ready_post", in_ready, 1);
        @(negedge clk);

        // Table-driven batches
        for (int k = 0; k < 3; k++) begin
            in_q.delete();
            exp_q.delete();
            for (int i = 0; i < int'(tbl[k].n); i++) begin
                in_q.push_back(tbl[k].words[8*i +: 8]);
                exp_q.push_back(tbl[k].exp_sorted[8*i +: 8]);
            end
            run_and_check($sformatf("tbl%0d", k), tbl[k].exp_lanes, tbl[k].bp);
        end

        // Single word with in_valid held through SORT/DRAIN
        begin
            int unsigned t = 0;
            got_data.delete();
            got_last.delete();
            last_seen = 1'b0;
            in_valid = 1'b1; in_data = 8'h7F; in_last = 1'b1;
            @(negedge clk);
            in_data = 8'h55; in_last = 1'b0;
            while (!in_ready && t < 100) begin
                chk("single_lanes", sort_data_in, 64'hFF_FF_FF_FF_FF_FF_FF_7F);
                @(negedge clk);
                t++;
            end
            in_valid = 1'b0;
            if (!in_ready) tmo_fail("single_return");
            chk("single_count", 64'(got_data.size()), 1);
            if (got_data.size() > 0) begin
                chk("single_data", got_data[0], 8'h7F);
                chk("single_last", got_last[0], 1);
            end
            @(negedge clk);
        end

        // Randomized batches against sorted-queue reference
        for (int k = 0; k < 25; k++) begin
            int unsigned n = $urandom_range(1, 8);
            in_q.delete();
            for (int i = 0; i < int'(n); i++)
                in_q.push_back(($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom));
            exp_q = in_q;
            exp_q.sort();
            run_and_check($sformatf("rnd%0d", k), lanes_of(0), $urandom_range(0, 2));
        end

        // Timeout: sorter never finishes
        hang = 1'b1;
        in_q = '{8'h10, 8'h20};
        got_data.delete();
        ovalid_seen = 0;
        send_batch();
        chk("to_sv_start", sort_valid, 1);
        repeat (15) @(negedge clk);
        chk("to_flag_early", sort_timeout, 0);
        chk("to_sv_early", sort_valid, 1);
        @(negedge clk);
        chk("to_flag", sort_timeout, 1);
        chk("to_sv_drop", sort_valid, 0);
        chk("to_in_ready", in_ready, 1);
        chk("to_busy", busy, 0);
        chk("to_no_out", 64'(ovalid_seen), 0);
        hang = 1'b0;
        in_q = '{8'h33, 8'h11, 8'h22};
        exp_q = '{8'h11, 8'h22, 8'h33};
        run_and_check("post_to", 64'hFF_FF_FF_FF_FF_22_11_33, 0);
        chk("to_sticky", sort_timeout, 1);

        // Reset mid-DRAIN after three words
        begin
            int unsigned t = 0;
            in_q = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd7, 8'd2, 8'd6, 8'd4};
            got_data.delete();
            got_last.delete();
            bp_mode = 0;
            send_batch();
            while (got_data.size() < 3 && t < 100) begin
                @(posedge clk);
                t++;
            end
            if (got_data.size() < 3) tmo_fail("mid_drain_wait");
            #2 reset = 1'b0;
            #1;
            chk("mr_out_valid", out_valid, 0);
            chk("mr_busy", busy, 0);
            chk("mr_sort_valid", sort_valid, 0);
            chk("mr_in_ready", in_ready, 0);
            chk("mr_timeout", sort_timeout, 0);
            chk("mr_out_data", out_data, 0);
            repeat (2) @(negedge clk);
            chk("mr_words", 64'(got_data.size()), 3);
            reset = 1'b1;
            #1 chk("mr_in_ready_pre", in_ready, 0);
            @(posedge clk);
            #1 chk("mr_in_ready_post", in_ready, 1);
            @(negedge clk);
            in_q = '{8'd4, 8'd4, 8'd0};
            exp_q = '{8'd0, 8'd4, 8'd4};
            run_and_check("after_rst", 64'hFF_FF_FF_FF_FF_00_04_04, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitonic_sort_ctrl.md
Name: bitonic_sort_ctrl

Overview:
Sequencer wrapping the parallel bitonic sorter for a word-serial stream. Collects up to NUM_INPUT words from a valid/ready input stream into a lane buffer and pads unused lanes. Drives the sorter's parallel input and valid, waits for its done, and captures the sorted vector. Streams the real (non-pad) words back out in ascending order on a valid/ready output. It sits between the serial system bus and the sorter instance.

Parameters:
NUM_INPUT, 8, sorter lane count; power of two, >= 2
DATA_WIDTH, 8, bits per word
MAX_WAIT, 64, SORT-state cycles allowed before timeout; >= 2

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  input word present
in_ready  output  1  controller accepts input word
in_data  input  DATA_WIDTH  input word
in_last  input  1  final word of batch; qualified by in_valid
sort_data_in  output  NUM_INPUT*DATA_WIDTH  to sorter data_in; lane i = bits [DATA_WIDTH*(i+1)-1 -: DATA_WIDTH]
sort_valid  output  1  to sorter valid
sort_done  input  1  from sorter done
sort_data_out  input  NUM_INPUT*DATA_WIDTH  from sorter data_out; lane 0 = smallest
out_valid  output  1  sorted word present
out_ready  input  1  downstream accepts word
out_data  output  DATA_WIDTH  sorted word
out_last  output  1  final real word of batch
busy  output  1  high in SORT or DRAIN
sort_timeout  output  1  sticky; sorter failed to finish within MAX_WAIT

Behaviour:
- All outputs registered.
- Reset (reset=0, async): state FILL, count=0, rd_idx=0, wait counter=0, sort_data_in=0, result buffer=0, and outputs in_ready=0, sort_valid=0, out_valid=0, out_data=0, out_last=0, busy=0, sort_timeout=0. in_ready rises on the first clk edge after reset deasserts.
- States: FILL, SORT, DRAIN.
- FILL:
  - in_ready=1.
  - On handshake (in_valid & in_ready), write in_data to lane count and increment count.
  - If in_last is set, or this is the word that brings count to NUM_INPUT:
    - Lanes count..NUM_INPUT-1 load all-ones (pad) on the same edge.
    - in_ready drops on the next cycle.
    - State becomes SORT with sort_valid=1.
  - count width is $clog2(NUM_INPUT+1). Words arriving while in_ready=0 are not accepted.
- SORT:
  - sort_valid is held at 1 and sort_data_in is held stable. busy=1. The wait counter increments each cycle.
  - On the first cycle sampling sort_done=1:
    - Capture sort_data_out into the result buffer.
    - On that edge: sort_valid goes to 0, state becomes DRAIN, rd_idx=0, out_valid=1, out_data=lane 0.
  - If the wait counter reaches MAX_WAIT with sort_done still 0:
    - sort_timeout is set (sticky until reset) and the batch is discarded.
    - sort_valid goes to 0, count=0, and the state returns to FILL.
  - If done and timeout happen on the same cycle, done wins.
- DRAIN:
  - out_valid=1, out_data = result lane rd_idx, out_last = (rd_idx == count-1).
  - out_data, out_valid and out_last hold stable while out_ready=0.
  - On handshake with out_last=0: rd_idx increments and the next lane appears on the following cycle. One word per cycle at full throughput.
  - On handshake with out_last=1:
    - out_valid goes to 0, count=0, busy=0, state becomes FILL.
    - in_ready=1 on the next cycle.
- Pads (all-ones) sort to the top lanes. Only lanes 0..count-1 are emitted. Genuine all-ones inputs are valid data and tie harmlessly with pads.
- in_last on the NUM_INPUT-th word behaves the same as a full batch. A batch of one word (in_last on first word) is legal: SORT runs, then exactly one output word with out_last=1.
- Reset asserted mid-SORT or mid-DRAIN aborts immediately to reset values. No partial output follows.

Test Plan:
- Bench sorter model asserts done 3 cycles after valid rises. Feed 5,3,8,1,7,2,6,4 (last on 4) with out_ready=1 -> outputs 1,2,3,4,5,6,7,8 on consecutive cycles, out_last only with 8. sort_data_in lanes 0..7 = 5,3,8,1,7,2,6,4. busy high from SORT entry to last handshake.
- Partial batch 9,2,5 (last on 5) -> sort_data_in lanes 3..7 = 0xFF. Output 2,5,9 with out_last on 9. No 0xFF words emitted.
- Backpressure: full batch, out_ready pattern 1,0,0,1,0,1... -> out_data is held during stalls. Same 8-word order. Exactly 8 handshakes.
- Timeout: MAX_WAIT=16, sorter model never asserts done -> sort_timeout=1 after 16 SORT cycles, sort_valid=0, in_ready=1 next cycle, no out_valid. A following good batch sorts correctly and sort_timeout stays 1.
- Reset (reset=0) asserted mid-DRAIN after 3 words -> out_valid=0, busy=0 immediately. After release, in_ready=1 at the first edge. A new batch 4,4,0 (last on 0) yields 0,4,4.
- Single word 0x7F with in_last -> one output 0x7F with out_last=1. in_valid held high throughout SORT/DRAIN is never accepted.
